// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if
//   The bundle around the decode stage. It carries the IF/ID side (id_valid,
//   id_pc, id_inst), the EX-side flush request (ex_flush), the stall back to
//   PC/IF-ID (stall_o), and the registered ID/EX contents (ex_*).
//   modport master : the decode stage itself. It consumes id_* and ex_flush,
//                    and drives stall_o and ex_*.
//   modport slave  : the surrounding pipeline. It drives id_* and ex_flush,
//                    and consumes stall_o and ex_*.
interface id_ex_stage_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        ex_flush;
  logic        stall_o;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_reg_we;
  logic        ex_mem_rd;
  logic        ex_mem_wr;

  modport master (
    input  id_valid, id_pc, id_inst, ex_flush,
    output stall_o, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5,
           ex_reg_we, ex_mem_rd, ex_mem_wr
  );

  modport slave (
    output id_valid, id_pc, id_inst, ex_flush,
    input  stall_o, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5,
           ex_reg_we, ex_mem_rd, ex_mem_wr
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   This is the RV32I decode stage plus the ID/EX pipeline register. It
//   decodes the IF/ID instruction (immediate and control bits) and drives the
//   register-file read addresses. It detects load-use hazards against the
//   load sitting in EX, and registers one instruction per cycle into EX.
// Ports
//   clk, rst          clock; synchronous active-high reset
//   bus (master)      id_* in, ex_flush in, stall_o out, ex_* out
//   rf_rs1_addr/rs2   combinational read addresses (id_inst[19:15]/[24:20])
//   rf_rs1_data/rs2   register-file read data
//   wb_we/rd/data     WB write port. It is used only when the WB bypass is
//                     built in.
// Configuration
//   ID_WB_BYPASS_EN   When defined, WB write data is forwarded into the
//                     decode operands (pair it with a RegFile without
//                     write-through). When undefined, the RegFile data is
//                     taken as-is (pair it with a write-through RegFile).
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  id_ex_stage_if.master   bus,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] immI, immS, immB, immU, immJ;

  assign inst   = bus.id_inst;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;

  assign immI = {{20{inst[31]}}, inst[31:20]};
  assign immS = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign immB = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign immU = {inst[31:12], 12'b0};
  assign immJ = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  logic [31:0] imm;
  logic        writesRd, memRd, memWr, usesRs1, usesRs2;

  always_comb begin
    imm      = '0;
    writesRd = 1'b0;
    memRd    = 1'b0;
    memWr    = 1'b0;
    usesRs1  = 1'b0;
    usesRs2  = 1'b0;
    case (opcode)
      OP_LUI:    begin imm = immU; writesRd = 1'b1; end
      OP_AUIPC:  begin imm = immU; writesRd = 1'b1; end
      OP_JAL:    begin imm = immJ; writesRd = 1'b1; end
      OP_JALR:   begin imm = immI; writesRd = 1'b1; usesRs1 = 1'b1; end
      OP_BRANCH: begin imm = immB; usesRs1 = 1'b1; usesRs2 = 1'b1; end
      OP_LOAD:   begin imm = immI; writesRd = 1'b1; memRd = 1'b1; usesRs1 = 1'b1; end
      OP_STORE:  begin imm = immS; memWr = 1'b1; usesRs1 = 1'b1; usesRs2 = 1'b1; end
      OP_OPIMM:  begin imm = immI; writesRd = 1'b1; usesRs1 = 1'b1; end
      OP_OP:     begin writesRd = 1'b1; usesRs1 = 1'b1; usesRs2 = 1'b1; end
      default:   ; // unknown opcodes pass through as a valid no-op
    endcase
  end

  // A load in EX whose destination feeds this instruction cannot be
  // forwarded in time. The consumer waits one cycle behind a bubble.
  // Writes to x0 never create a dependency.
  logic loadUse;
  assign loadUse = bus.ex_valid && bus.ex_mem_rd && (bus.ex_rd != 5'd0) &&
                   bus.id_valid &&
                   ((usesRs1 && (rs1 == bus.ex_rd)) ||
                    (usesRs2 && (rs2 == bus.ex_rd)));

  // A flush discards the dependent instruction anyway, so it suppresses the stall.
  assign bus.stall_o = loadUse && !bus.ex_flush;

  logic [31:0] rs1Data, rs2Data;
`ifdef ID_WB_BYPASS_EN
  assign rs1Data = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1)) ? wb_data : rf_rs1_data;
  assign rs2Data = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2)) ? wb_data : rf_rs2_data;
`else
  assign rs1Data = rf_rs1_data;
  assign rs2Data = rf_rs2_data;
  logic unusedWb;
  assign unusedWb = ^{wb_we, wb_rd, wb_data};
`endif

  // The flush, load-use and empty-slot cases all collapse to the same
  // bubble. A bubble clears only the valid and control bits, and the
  // datapath fields keep their old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_pc       <= '0;
      bus.ex_rs1_data <= '0;
      bus.ex_rs2_data <= '0;
      bus.ex_imm      <= '0;
      bus.ex_rs1      <= '0;
      bus.ex_rs2      <= '0;
      bus.ex_rd       <= '0;
      bus.ex_opcode   <= '0;
      bus.ex_funct3   <= '0;
      bus.ex_funct7b5 <= 1'b0;
      bus.ex_reg_we   <= 1'b0;
      bus.ex_mem_rd   <= 1'b0;
      bus.ex_mem_wr   <= 1'b0;
    end else if (bus.ex_flush || loadUse || !bus.id_valid) begin
      bus.ex_valid  <= 1'b0;
      bus.ex_reg_we <= 1'b0;
      bus.ex_mem_rd <= 1'b0;
      bus.ex_mem_wr <= 1'b0;
    end else begin
      bus.ex_valid    <= 1'b1;
      bus.ex_pc       <= bus.id_pc;
      bus.ex_rs1_data <= rs1Data;
      bus.ex_rs2_data <= rs2Data;
      bus.ex_imm      <= imm;
      bus.ex_rs1      <= rs1;
      bus.ex_rs2      <= rs2;
      bus.ex_rd       <= rd;
      bus.ex_opcode   <= opcode;
      bus.ex_funct3   <= inst[14:12];
      bus.ex_funct7b5 <= inst[30];
      bus.ex_reg_we   <= writesRd && (rd != 5'd0);
      bus.ex_mem_rd   <= memRd;
      bus.ex_mem_wr   <= memWr;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//   Directed bench for id_ex_stage. A behavioural model of the ID/EX register
//   is kept in the bench and compared on every falling edge. Hand-computed
//   literal checks pin the model at the key points.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic [31:0] rfMem [32];

  id_ex_stage_if bus();

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  assign rf_rs1_data = rfMem[rf_rs1_addr];
  assign rf_rs2_data = rfMem[rf_rs2_addr];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] imm;
    logic        we, mrd, mwr, u1, u2;
  } dec_t;

  typedef struct {
    logic        v;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  r1, r2, rd;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7, we, mrd, mwr;
  } ex_t;

  // Immediates are built with signed shifts of the whole word, not by
  // concatenating bit fields.
  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    logic signed [31:0] si;
    logic [31:0] sgn;
    bit isI, isS, isB, isU, isJ, wr;
    si  = i;
    sgn = 32'(si >>> 31);
    d = '{imm: 32'd0, we: 1'b0, mrd: 1'b0, mwr: 1'b0, u1: 1'b0, u2: 1'b0};
    isI = 0; isS = 0; isB = 0; isU = 0; isJ = 0; wr = 0;
    case (i[6:0])
      7'b0110111, 7'b0010111: begin isU = 1; wr = 1; end
      7'b1101111: begin isJ = 1; wr = 1; end
      7'b1100111: begin isI = 1; wr = 1; d.u1 = 1; end
      7'b1100011: begin isB = 1; d.u1 = 1; d.u2 = 1; end
      7'b0000011: begin isI = 1; wr = 1; d.mrd = 1; d.u1 = 1; end
      7'b0100011: begin isS = 1; d.mwr = 1; d.u1 = 1; d.u2 = 1; end
      7'b0010011: begin isI = 1; wr = 1; d.u1 = 1; end
      7'b0110011: begin wr = 1; d.u1 = 1; d.u2 = 1; end
      default: ;
    endcase
    if (isI) d.imm = 32'(si >>> 20);
    if (isS) d.imm = 32'((si >>> 25) <<< 5) | 32'(i[11:7]);
    if (isB) d.imm = (sgn << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
    if (isU) d.imm = i & 32'hFFFFF000;
    if (isJ) d.imm = (sgn << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
    d.we = wr && (i[11:7] != 5'd0);
    return d;
  endfunction

  ex_t m;
  bit  started = 0;

  function automatic logic hazard();
    dec_t d;
    d = decode(bus.id_inst);
    return m.v && m.mrd && (m.rd != 0) && bus.id_valid &&
           ((d.u1 && bus.id_inst[19:15] == m.rd) || (d.u2 && bus.id_inst[24:20] == m.rd));
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r);
`ifdef ID_WB_BYPASS_EN
    if (wb_we && wb_rd != 0 && wb_rd == r) return wb_data;
`endif
    return rfMem[r];
  endfunction

  always @(posedge clk) begin
    dec_t d;
    started = 1;
    d = decode(bus.id_inst);
    if (rst) begin
      m = '{v: 0, pc: 0, d1: 0, d2: 0, imm: 0, r1: 0, r2: 0, rd: 0,
            op: 0, f3: 0, f7: 0, we: 0, mrd: 0, mwr: 0};
    end else if (bus.ex_flush || hazard() || !bus.id_valid) begin
      m.v = 0; m.we = 0; m.mrd = 0; m.mwr = 0;
    end else begin
      m.v   = 1;
      m.pc  = bus.id_pc;
      m.d1  = operand(bus.id_inst[19:15]);
      m.d2  = operand(bus.id_inst[24:20]);
      m.imm = d.imm;
      m.r1  = bus.id_inst[19:15];
      m.r2  = bus.id_inst[24:20];
      m.rd  = bus.id_inst[11:7];
      m.op  = bus.id_inst[6:0];
      m.f3  = bus.id_inst[14:12];
      m.f7  = bus.id_inst[30];
      m.we  = d.we;
      m.mrd = d.mrd;
      m.mwr = d.mwr;
    end
  end

  // Compare process: the outputs are meaningful on every cycle after the first edge.
  always @(negedge clk) begin
    if (started) begin
      chk("m_valid",  32'(bus.ex_valid),    32'(m.v));
      chk("m_pc",     bus.ex_pc,            m.pc);
      chk("m_rs1d",   bus.ex_rs1_data,      m.d1);
      chk("m_rs2d",   bus.ex_rs2_data,      m.d2);
      chk("m_imm",    bus.ex_imm,           m.imm);
      chk("m_rs1",    32'(bus.ex_rs1),      32'(m.r1));
      chk("m_rs2",    32'(bus.ex_rs2),      32'(m.r2));
      chk("m_rd",     32'(bus.ex_rd),       32'(m.rd));
      chk("m_op",     32'(bus.ex_opcode),   32'(m.op));
      chk("m_f3",     32'(bus.ex_funct3),   32'(m.f3));
      chk("m_f7",     32'(bus.ex_funct7b5), 32'(m.f7));
      chk("m_we",     32'(bus.ex_reg_we),   32'(m.we));
      chk("m_memrd",  32'(bus.ex_mem_rd),   32'(m.mrd));
      chk("m_memwr",  32'(bus.ex_mem_wr),   32'(m.mwr));
      chk("m_stall",  32'(bus.stall_o),     32'(hazard() && !bus.ex_flush));
      chk("m_rfa1",   32'(rf_rs1_addr),     32'(bus.id_inst[19:15]));
      chk("m_rfa2",   32'(rf_rs2_addr),     32'(bus.id_inst[24:20]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic setIn(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic fl);
    bus.id_valid = v;
    bus.id_pc    = pc;
    bus.id_inst  = inst;
    bus.ex_flush = fl;
    $display("[TB] t=%0t rst=%0b valid=%0b pc=%h inst=%h flush=%0b", $time, rst, v, pc, inst, fl);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADDI_X1 = 32'hFFF00093; // addi x1,x0,-1
  localparam logic [31:0] SW_X2   = 32'h0020A423; // sw x2,8(x1)
  localparam logic [31:0] LW_X5   = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] ADD_X6  = 32'h00028333; // add x6,x5,x0
  localparam logic [31:0] LW_X0   = 32'h0000A003; // lw x0,0(x1)
  localparam logic [31:0] ADD_00  = 32'h00000333; // add x6,x0,x0
  localparam logic [31:0] ADDI_X7 = 32'h00130393; // addi x7,x6,1

  logic [6:0] ops [9];

  initial begin
    for (int i = 0; i < 32; i++) rfMem[i] = 32'hA0000000 + 32'(i);
    rfMem[6] = 32'd0;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

    // Reset held two cycles with a valid instruction presented.
    setIn(1, 32'h100, ADDI_X1, 0);
    tick(); tick();
    chk("rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_pc",    bus.ex_pc,         32'd0);
    chk("rst_imm",   bus.ex_imm,        32'd0);
    chk("rst_stall", 32'(bus.stall_o),  32'd0);

    // The first edge after release loads addi.
    rst = 0;
    tick();
    chk("addi_imm", bus.ex_imm,          32'hFFFFFFFF);
    chk("addi_rd",  32'(bus.ex_rd),      32'd1);
    chk("addi_we",  32'(bus.ex_reg_we),  32'd1);
    chk("addi_pc",  bus.ex_pc,           32'h100);

    setIn(1, 32'h104, SW_X2, 0);
    tick();
    chk("sw_imm", bus.ex_imm,         32'd8);
    chk("sw_wr",  32'(bus.ex_mem_wr), 32'd1);
    chk("sw_we",  32'(bus.ex_reg_we), 32'd0);

    // Load-use: one stall cycle, one bubble, then the consumer proceeds.
    setIn(1, 32'h108, LW_X5, 0);
    tick();
    setIn(1, 32'h10C, ADD_X6, 0);
    #1 chk("lu_stall", 32'(bus.stall_o), 32'd1);
    tick();
    chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
    chk("lu_stall2", 32'(bus.stall_o),  32'd0);
    tick();
    chk("lu_add_v",  32'(bus.ex_valid), 32'd1);
    chk("lu_add_rd", 32'(bus.ex_rd),    32'd6);

    // A load to x0 never stalls.
    setIn(1, 32'h110, LW_X0, 0);
    tick();
    setIn(1, 32'h114, ADD_00, 0);
    #1 chk("x0_stall", 32'(bus.stall_o), 32'd0);
    tick();
    chk("x0_valid", 32'(bus.ex_valid), 32'd1);

    // Flush beats stall.
    setIn(1, 32'h118, LW_X5, 0);
    tick();
    setIn(1, 32'h11C, ADD_X6, 1);
    #1 chk("fl_stall", 32'(bus.stall_o), 32'd0);
    tick();
    chk("fl_valid", 32'(bus.ex_valid),  32'd0);
    chk("fl_memrd", 32'(bus.ex_mem_rd), 32'd0);
    setIn(1, 32'h200, ADD_X6, 0);
    #1 chk("fl_nostall", 32'(bus.stall_o), 32'd0);
    tick();

    // WB bypass into rs1.
    wb_we = 1; wb_rd = 5'd6; wb_data = 32'h12345678;
    setIn(1, 32'h204, ADDI_X7, 0);
    tick();
`ifdef ID_WB_BYPASS_EN
    chk("byp_rs1", bus.ex_rs1_data, 32'h12345678);
`else
    chk("byp_rs1", bus.ex_rs1_data, 32'h00000000);
`endif
    rfMem[6] = 32'h00000066;
    wb_rd = 5'd0;
    setIn(1, 32'h208, ADDI_X7, 0);
    tick();
    chk("byp_x0", bus.ex_rs1_data, 32'h00000066);
    wb_we = 0;

    // Unknown opcode: valid, no control, zero immediate.
    setIn(1, 32'h20C, 32'hFFFFFFFF, 0);
    tick();
    chk("ill_valid", 32'(bus.ex_valid),  32'd1);
    chk("ill_ctl",   32'({bus.ex_reg_we, bus.ex_mem_rd, bus.ex_mem_wr}), 32'd0);
    chk("ill_imm",   bus.ex_imm,         32'd0);

    // An empty slot bubbles but keeps the datapath fields.
    setIn(0, 32'h999, ADD_X6, 0);
    tick();
    chk("idle_valid", 32'(bus.ex_valid), 32'd0);
    chk("idle_pc",    bus.ex_pc,         32'h20C);

    // Reset in the middle of a stall.
    setIn(1, 32'h300, LW_X5, 0);
    tick();
    setIn(1, 32'h304, ADD_X6, 0);
    #1 chk("rs_stall", 32'(bus.stall_o), 32'd1);
    rst = 1;
    tick();
    chk("rs_valid",  32'(bus.ex_valid), 32'd0);
    chk("rs_stall2", 32'(bus.stall_o),  32'd0);
    rst = 0;

    // Mixed formats with random upper bits, checked by the model.
    for (int k = 0; k < 27; k++) begin
      logic [31:0] r;
      logic [31:0] rv;
      r  = $urandom();
      rv = $urandom_range(0, 7);
      rfMem[r[19:15]] = $urandom();
      setIn(rv != 0, 32'h400 + 32'(k * 4), {r[31:7], ops[k % 9]}, rv == 1);
      tick();
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode stage and ID/EX pipeline register of the RV32I pipeline core. Takes the fetched instruction from IF/ID and drives the register-file read addresses. It decodes immediate and control fields, detects load-use hazards, and registers one instruction per cycle into EX. It produces the stall that freezes PC and IF/ID, and it accepts the branch/jump flush from EX.

## Interface
- XLEN, 32, datapath width (only 32 supported)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  IF/ID holds a real instruction
- id_pc  in  32  PC of IF/ID instruction
- id_inst  in  32  IF/ID instruction word
- rf_rs1_addr  out  5  combinational id_inst[19:15], to RegFile rsR1
- rf_rs2_addr  out  5  combinational id_inst[24:20], to RegFile rsR2
- rf_rs1_data  in  32  RegFile dataR1
- rf_rs2_data  in  32  RegFile dataR2
- wb_we, wb_rd, wb_data  in  1/5/32  WB write port, same values as RegFile RegWEn/rsW/dataW
- ex_flush  in  1  EX redirect (taken branch/jump); kill ID/EX contents
- stall_o  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  32 each  registered operands
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered register indices
- ex_opcode  out  7; ex_funct3  out  3; ex_funct7b5  out  1  registered fields for ALU control
- ex_reg_we, ex_mem_rd, ex_mem_wr  out  1 each  registered control

## Operation
- Opcodes handled: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
- Immediates are sign-extended to 32 bits. Formats: I {20{i[31]},i[31:20]}; S {..,i[31:25],i[11:7]}; B {..,i[7],i[30:25],i[11:8],0}; U {i[31:12],12'b0}; J {..,i[19:12],i[20],i[30:21],0}.
- R-type has imm 0. Unrecognized opcode gives imm 0, all control bits 0, and ex_valid still set.
- reg_we = (LUI|AUIPC|JAL|JALR|LOAD|OP-IMM|OP) & rd!=0. mem_rd = LOAD. mem_wr = STORE.
- uses_rs1 = OP|OP-IMM|LOAD|STORE|BRANCH|JALR. uses_rs2 = OP|STORE|BRANCH.
- load_use = ex_valid & ex_mem_rd & ex_rd!=0 & id_valid & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- stall_o = load_use & ~ex_flush.
- Register update priority, highest first:
  - rst: all outputs 0.
  - ex_flush: bubble.
  - load_use: bubble; IF/ID is held upstream.
  - id_valid: load the decoded instruction.
  - otherwise: bubble.
- Bubble: ex_valid, ex_reg_we, ex_mem_rd and ex_mem_wr become 0; the other fields hold their previous values.

## Timing
- Decode-to-EX latency is 1 cycle. An instruction present at edge N appears on ex_* after edge N.
- stall_o is valid in the same cycle as the hazard. It lasts exactly 1 cycle per load-use pair, because the bubble clears ex_mem_rd.
- Flush and stall in the same cycle: flush wins, stall_o=0 and a bubble is loaded.
- rst overrides everything on the next edge. Reset mid-stall clears the stall next cycle, since ex_valid becomes 0.
- A hazard requires an index match and rd!=0. x0 never triggers a stall.

## Configuration
- ID_WB_BYPASS_EN defined: operand forwarding from WB into decode.
  - If wb_we & wb_rd!=0 & wb_rd==rs1, then ex_rs1_data is loaded from wb_data. rs2 is handled the same way.
  - Use with RegFile WRITE_THROUGH=0.
- ID_WB_BYPASS_EN undefined: ex_rsX_data = rf_rsX_data directly. wb_* ports are ignored.
  - Requires RegFile WRITE_THROUGH=1.

## Test plan
- Reset: hold rst 2 cycles with id_valid=1 -> all ex_* outputs 0, stall_o=0. After release, the first edge loads id_inst.
- Decode: id_inst=32'hFFF00093 (addi x1,x0,-1), pc=32'h100 -> ex_imm=32'hFFFFFFFF, ex_rd=1, ex_reg_we=1, ex_pc=32'h100. sw x2,8(x1) -> ex_imm=8, ex_mem_wr=1, ex_reg_we=0.
- Load-use: lw x5,0(x1) then add x6,x5,x0 -> stall_o=1 for exactly 1 cycle; one bubble (ex_valid=0); add reaches EX next cycle. Same with lw x0 -> no stall.
- Flush priority: ex_flush=1 while a load-use hazard is present -> stall_o=0, next ex_valid=0, ex_mem_rd=0.
- WB bypass (macro defined): wb_we=1, wb_rd=6, wb_data=32'h12345678, rf_rs1_data=0, rs1=6 -> ex_rs1_data=32'h12345678. wb_rd=0 -> rf data used. Macro undefined -> rf data always used.
- Illegal opcode 7'b1111111 with id_valid=1 -> ex_valid=1, all control bits 0, ex_imm=0.
